// File: rtl/lcd_refresh_ctrl_if.sv
// lcd_refresh_ctrl_if: image ROM read port plus KS0108-style graphic LCD pins
//   rom_addr        {chip, page[2:0], col[5:0]} read address
//   rom_data        ROM read data, valid one cycle after rom_addr
//   graphic_lcd_*   8-bit bus, rw, en strobe, di, active-low rst, cs1/cs2
interface lcd_refresh_ctrl_if;
    logic [9:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] graphic_lcd_d;
    logic       graphic_lcd_rw;
    logic       graphic_lcd_en;
    logic       graphic_lcd_di;
    logic       graphic_lcd_rst;
    logic       graphic_lcd_cs1;
    logic       graphic_lcd_cs2;
    modport master (
        output rom_addr, graphic_lcd_d, graphic_lcd_rw, graphic_lcd_en, graphic_lcd_di,
               graphic_lcd_rst, graphic_lcd_cs1, graphic_lcd_cs2,
        input  rom_data
    );
    modport slave (
        input  rom_addr, graphic_lcd_d, graphic_lcd_rw, graphic_lcd_en, graphic_lcd_di,
               graphic_lcd_rst, graphic_lcd_cs1, graphic_lcd_cs2,
        output rom_data
    );
endinterface

// File: rtl/lcd_refresh_ctrl.sv
// lcd_refresh_ctrl: resets/initialises a two-chip 128x64 LCD and streams frames from an image ROM
//   clk, rst_n      clock, asynchronous active-low reset
//   auto_i          level: refresh frames back to back while high
//   manual_i        rising edge requests one frame (ignored while busy)
//   busy_o          high in every state except IDLE
//   frame_done_o    one-cycle pulse at end of frame
//   bus             ROM read port and panel pins (master side)
module lcd_refresh_ctrl #(
    parameter int T_SETUP    = 2,
    parameter int T_EN_HIGH  = 4,
    parameter int T_HOLD     = 2,
    parameter int RST_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic auto_i,
    input  logic manual_i,
    output logic busy_o,
    output logic frame_done_o,
    lcd_refresh_ctrl_if.master bus
);
    localparam logic [2:0] RST_HOLD   = 3'd0;
    localparam logic [2:0] INIT_ON    = 3'd1;
    localparam logic [2:0] INIT_LINE  = 3'd2;
    localparam logic [2:0] IDLE       = 3'd3;
    localparam logic [2:0] SET_PAGE   = 3'd4;
    localparam logic [2:0] SET_COL    = 3'd5;
    localparam logic [2:0] WRITE_DATA = 3'd6;
    localparam logic [2:0] FRAME_END  = 3'd7;
    localparam int CW = 16;
    localparam logic [CW-1:0] T_LAST   = CW'(T_SETUP + T_EN_HIGH + T_HOLD - 1);
    localparam logic [CW-1:0] EN_ON    = CW'(T_SETUP);
    localparam logic [CW-1:0] EN_OFF   = CW'(T_SETUP + T_EN_HIGH);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] CAPTURE  = CW'(1);

    logic [2:0]    st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          chip, chip_n;
    logic [2:0]    page, page_n;
    logic [5:0]    col, col_n;
    logic          man_q1, man_q2;
    logic          start, xfer_n, init_n;
    logic [7:0]    cmd_n;

    assign start  = auto_i | (man_q1 & ~man_q2);
    // cnt is the cycle index inside the current transfer (or the panel reset timer)
    assign xfer_n = st_n != RST_HOLD && st_n != IDLE && st_n != FRAME_END;
    assign init_n = st_n == INIT_ON || st_n == INIT_LINE;
    assign cmd_n  = st_n == INIT_ON ? 8'h3F : st_n == INIT_LINE ? 8'hC0 :
                    st_n == SET_PAGE ? {5'b10111, page_n} : 8'h40;
    assign bus.graphic_lcd_rw = 1'b0;

    always_comb begin
        st_n   = st;
        cnt_n  = '0;
        chip_n = chip;
        page_n = page;
        col_n  = col;
        if (st == RST_HOLD) begin
            cnt_n = cnt + 1'b1;
            if (cnt == RST_LAST) begin
                st_n  = INIT_ON;
                cnt_n = '0;
            end
        end else if (st == IDLE) begin
            if (start) begin
                st_n   = SET_PAGE;
                chip_n = 1'b0;
                page_n = '0;
                col_n  = '0;
            end
        end else if (st == FRAME_END) begin
            st_n = IDLE;
        end else if (cnt != T_LAST) begin
            cnt_n = cnt + 1'b1;
        end else if (st == INIT_ON) begin
            st_n = INIT_LINE;
        end else if (st == INIT_LINE) begin
            st_n = IDLE;
        end else if (st == SET_PAGE) begin
            st_n = SET_COL;
        end else if (st == SET_COL) begin
            st_n = WRITE_DATA;
        end else begin
            // col wraps 63 -> 0 naturally; page 7 wraps to 0 as the right chip is selected
            col_n = col + 1'b1;
            if (col == 6'd63) begin
                st_n   = (chip && page == 3'd7) ? FRAME_END : SET_PAGE;
                page_n = page + 1'b1;
                if (page == 3'd7) chip_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st                  <= RST_HOLD;
            cnt                 <= '0;
            chip                <= 1'b0;
            page                <= '0;
            col                 <= '0;
            man_q1              <= 1'b0;
            man_q2              <= 1'b0;
            busy_o              <= 1'b0;
            frame_done_o        <= 1'b0;
            bus.rom_addr        <= '0;
            bus.graphic_lcd_d   <= '0;
            bus.graphic_lcd_en  <= 1'b0;
            bus.graphic_lcd_di  <= 1'b0;
            bus.graphic_lcd_rst <= 1'b0;
            bus.graphic_lcd_cs1 <= 1'b0;
            bus.graphic_lcd_cs2 <= 1'b0;
        end else begin
            st           <= st_n;
            cnt          <= cnt_n;
            chip         <= chip_n;
            page         <= page_n;
            col          <= col_n;
            man_q1       <= manual_i;
            man_q2       <= man_q1;
            busy_o       <= st_n != IDLE;
            frame_done_o <= st_n == FRAME_END;
            if (st_n == INIT_ON) bus.graphic_lcd_rst <= 1'b1;
            bus.graphic_lcd_en <= xfer_n && cnt_n >= EN_ON && cnt_n < EN_OFF;
            if (!xfer_n) begin
                bus.graphic_lcd_cs1 <= 1'b0;
                bus.graphic_lcd_cs2 <= 1'b0;
            end else if (cnt_n == '0) begin
                bus.graphic_lcd_cs1 <= init_n || !chip_n;
                bus.graphic_lcd_cs2 <= init_n || chip_n;
                bus.graphic_lcd_di  <= st_n == WRITE_DATA;
                if (st_n != WRITE_DATA) bus.graphic_lcd_d <= cmd_n;
            end
            // ROM byte requested in the previous transfer's last hold cycle arrives in setup cycle 0
            if (st_n == WRITE_DATA && cnt_n == CAPTURE) bus.graphic_lcd_d <= bus.rom_data;
            if (xfer_n && cnt_n == T_LAST)
                bus.rom_addr <= {chip_n, page_n, st_n == WRITE_DATA ? col_n + 1'b1 : 6'd0};
        end
    end
endmodule
